// File: rtl/gshare_bp.sv
// Gshare/gselect global-history branch predictor with a RAM-friendly PHT.
// A walk FSM initialises the table instead of a flop-array reset.
module gshare_bp #(
    parameter int S_PC_IDX    = 10,
    parameter int S_PC_OFFSET = 2,
    parameter int S_BHR       = 8,
    parameter int S_CTR       = 2,
    parameter int HASH_XOR    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_tbl,
    input  logic             pred_valid,
    input  logic [31:0]      pred_pc,
    output logic             pred_ready,
    output logic             pred_take,
    output logic [S_BHR-1:0] pred_ghr,
    input  logic             upd_valid,
    input  logic [31:0]      upd_pc,
    input  logic [S_BHR-1:0] upd_ghr,
    input  logic             upd_br_en,
    input  logic             upd_mispred,
    output logic             init_busy
);

    localparam int DEPTH = 2 ** S_PC_IDX;
    localparam logic [S_CTR-1:0] INIT_CTR = S_CTR'(2 ** (S_CTR - 1) - 1);
    localparam logic [S_CTR-1:0] CTR_MAX  = '1;
    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Truncating {pc_idx, ghr} yields the gselect concatenation for any S_BHR <= S_PC_IDX.
    function automatic logic [S_PC_IDX-1:0] hash_idx(input logic [S_PC_IDX-1:0] pc_idx,
                                                     input logic [S_BHR-1:0] ghr);
        if (HASH_XOR != 0) return pc_idx ^ S_PC_IDX'(ghr);
        else return S_PC_IDX'({pc_idx, ghr});
    endfunction

    logic [0:0]          state_q, state_d;
    logic [S_PC_IDX-1:0] ptr_q, ptr_d;
    logic [S_BHR-1:0]    ghr_q, ghr_d;
    logic [S_CTR-1:0]    pht_mem [DEPTH];

    logic                run;
    logic [S_PC_IDX-1:0] rd_idx, upd_idx, wr_idx;
    logic [S_CTR-1:0]    rd_ctr, upd_ctr, upd_ctr_nxt, wr_data;
    logic                wr_en;
    logic                unused_pc;

    assign unused_pc = ^{pred_pc, upd_pc};

    assign run     = (state_q == ST_RUN);
    assign rd_idx  = hash_idx(pred_pc[S_PC_OFFSET +: S_PC_IDX], ghr_q);
    assign upd_idx = hash_idx(upd_pc[S_PC_OFFSET +: S_PC_IDX], upd_ghr);
    assign rd_ctr  = pht_mem[rd_idx];
    assign upd_ctr = pht_mem[upd_idx];

    assign pred_ready = run;
    assign init_busy  = ~run;
    assign pred_take  = run & rd_ctr[S_CTR-1];
    assign pred_ghr   = ghr_q;

    always_comb begin
        upd_ctr_nxt = upd_ctr;
        if (upd_br_en) begin
            if (upd_ctr != CTR_MAX) upd_ctr_nxt = upd_ctr + S_CTR'(1);
        end else begin
            if (upd_ctr != '0) upd_ctr_nxt = upd_ctr - S_CTR'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        ghr_d   = ghr_q;
        wr_en   = 1'b0;
        wr_idx  = upd_idx;
        wr_data = upd_ctr_nxt;
        case (state_q)
            ST_INIT: begin
                if (flush_tbl) begin
                    ptr_d = '0;
                    ghr_d = '0;
                end else begin
                    wr_en   = 1'b1;
                    wr_idx  = ptr_q;
                    wr_data = INIT_CTR;
                    ptr_d   = ptr_q + S_PC_IDX'(1);
                    if (ptr_q == '1) state_d = ST_RUN;
                end
            end
            default: begin
                if (flush_tbl) begin
                    state_d = ST_INIT;
                    ptr_d   = '0;
                    ghr_d   = '0;
                end else begin
                    wr_en = upd_valid;
                    // A mispredict repair overrides this cycle's speculative shift.
                    if (upd_valid && upd_mispred)
                        ghr_d = {upd_ghr[S_BHR-2:0], upd_br_en};
                    else if (pred_valid)
                        ghr_d = {ghr_q[S_BHR-2:0], pred_take};
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_INIT;
            ptr_q   <= '0;
            ghr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ghr_q   <= ghr_d;
        end
    end

    // No reset on the table so it maps onto RAM; the walk provides initial contents.
    always_ff @(posedge clk) begin
        if (wr_en) pht_mem[wr_idx] <= wr_data;
    end

endmodule

// File: tb/tb_gshare_bp.sv
// Bench for gshare_bp: gshare and gselect instances share stimulus and are
// checked every cycle against an array-based reference model.
module tb_gshare_bp;

    logic clk = 1'b0;
    logic rst;
    logic flush_tbl, pred_valid, upd_valid, upd_br_en, upd_mispred;
    logic [31:0] pred_pc, upd_pc;
    logic [7:0]  upd_ghr;

    logic       rdy  [2];
    logic       take [2];
    logic [7:0] pghr [2];
    logic       busy [2];

    int n_cmp = 0;
    int n_bad = 0;

    int m_pht [2][1024];
    int m_ghr [2];
    bit m_run;
    int m_cnt;

    always #5 clk = ~clk;

    gshare_bp #(.HASH_XOR(1)) u_x (
        .clk(clk), .rst(rst), .flush_tbl(flush_tbl),
        .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_ready(rdy[0]),
        .pred_take(take[0]), .pred_ghr(pghr[0]),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_ghr(upd_ghr),
        .upd_br_en(upd_br_en), .upd_mispred(upd_mispred), .init_busy(busy[0])
    );

    gshare_bp #(.HASH_XOR(0)) u_s (
        .clk(clk), .rst(rst), .flush_tbl(flush_tbl),
        .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_ready(rdy[1]),
        .pred_take(take[1]), .pred_ghr(pghr[1]),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_ghr(upd_ghr),
        .upd_br_en(upd_br_en), .upd_mispred(upd_mispred), .init_busy(busy[1])
    );

    // instance 0: idx = pc_idx ^ ghr; instance 1: idx = low 10 bits of pc_idx*256 + ghr
    function automatic int midx(int inst, logic [31:0] pc, int g);
        int p;
        p = int'((pc >> 2) & 32'h3FF);
        if (inst == 0) return p ^ g;
        return (p * 256 + g) % 1024;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(bit pv, logic [31:0] ppc, bit uv, logic [31:0] upc,
                         logic [7:0] ug, bit br, bit mp);
        pred_valid = pv; pred_pc = ppc; upd_valid = uv; upd_pc = upc;
        upd_ghr = ug; upd_br_en = br; upd_mispred = mp; flush_tbl = 1'b0;
    endtask

    task automatic idle();
        drive(0, 32'h0, 0, 32'h0, 8'h0, 0, 0);
    endtask

    // Check all outputs against the model at the negedge, then advance the model by one edge.
    task automatic cyc();
        int t;
        int k;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("ready%0d", i), rdy[i], m_run);
            chk($sformatf("busy%0d", i), busy[i], !m_run);
            chk($sformatf("ghr%0d", i), pghr[i], m_ghr[i]);
            chk($sformatf("take%0d", i), take[i],
                m_run ? (m_pht[i][midx(i, pred_pc, m_ghr[i])] >= 2) : 0);
        end
        if (rst) begin
            m_run = 0; m_cnt = 0; m_ghr[0] = 0; m_ghr[1] = 0;
        end else if (!m_run) begin
            if (flush_tbl) begin
                m_cnt = 0; m_ghr[0] = 0; m_ghr[1] = 0;
            end else begin
                m_cnt++;
                if (m_cnt == 1024) begin
                    m_run = 1;
                    for (int i = 0; i < 2; i++)
                        for (int j = 0; j < 1024; j++) m_pht[i][j] = 1;
                end
            end
        end else if (flush_tbl) begin
            m_run = 0; m_cnt = 0; m_ghr[0] = 0; m_ghr[1] = 0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                t = (m_pht[i][midx(i, pred_pc, m_ghr[i])] >= 2) ? 1 : 0;
                if (upd_valid) begin
                    k = midx(i, upd_pc, int'(upd_ghr));
                    if (upd_br_en && m_pht[i][k] < 3) m_pht[i][k]++;
                    if (!upd_br_en && m_pht[i][k] > 0) m_pht[i][k]--;
                end
                if (upd_valid && upd_mispred)
                    m_ghr[i] = (int'(upd_ghr) * 2 + int'(upd_br_en)) % 256;
                else if (pred_valid)
                    m_ghr[i] = (m_ghr[i] * 2 + t) % 256;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic upd(logic [31:0] pc, logic [7:0] g, bit br);
        drive(0, 32'h0, 1, pc, g, br, 0);
        cyc();
        idle();
    endtask

    // A repair with upd_ghr = v>>1 and outcome v[0] forces both GHRs to v.
    task automatic set_ghr(logic [7:0] v);
        drive(0, 32'h0, 1, 32'hFFC, v >> 1, v[0], 1);
        cyc();
        idle();
    endtask

    task automatic wait_ready(string tag);
        int n;
        n = 0;
        while (!rdy[0] && n < 2000) begin
            cyc();
            n++;
        end
        chk(tag, n, 1024);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        m_run = 0; m_cnt = 0; m_ghr[0] = 0; m_ghr[1] = 0;
        #1;
        chk("rst_ready", rdy[0], 0);
        chk("rst_busy", busy[0], 1);
        chk("rst_take", take[0], 0);
        chk("rst_ghr", pghr[0], 0);
        cyc();
        cyc();
        rst = 1'b0;

        // Initial walk, lookups ignored meanwhile
        drive(1, 32'h100, 0, 32'h0, 8'h0, 0, 0);
        wait_ready("init_len");
        idle();
        for (int i = 0; i < 4; i++) begin
            pred_pc = $urandom_range(0, 1023) * 4;
            #1;
            chk("dflt_take", take[0], 0);
            cyc();
        end

        // Hash aliasing: pc 0x40/ghr 0x10 lands on entry 0 only in gshare
        upd(32'h40, 8'h10, 1);
        upd(32'h40, 8'h10, 1);
        pred_pc = 32'h0;
        #1;
        chk("alias_xor", take[0], 1);
        chk("alias_sel", take[1], 0);
        cyc();

        // Training at pc 0x100, ghr 0
        upd(32'h100, 8'h00, 1);
        upd(32'h100, 8'h00, 1);
        pred_pc = 32'h100;
        #1;
        chk("train_t", take[0], 1);
        cyc();
        upd(32'h300, 8'h02, 1);
        upd(32'h300, 8'h02, 1);
        upd(32'h500, 8'h05, 1);
        upd(32'h500, 8'h05, 1);

        // Speculative history: predictions 1,0,1 from GHR 0
        drive(1, 32'h100, 0, 32'h0, 8'h0, 0, 0);
        #1; chk("spec_g0", pghr[0], 8'h00); chk("spec_t0", take[0], 1);
        cyc();
        pred_pc = 32'h200;
        #1; chk("spec_g1", pghr[0], 8'h01); chk("spec_t1", take[0], 0);
        cyc();
        pred_pc = 32'h300;
        #1; chk("spec_g2", pghr[0], 8'h02); chk("spec_t2", take[0], 1);
        cyc();
        idle();
        #1; chk("spec_g3", pghr[0], 8'h05);

        // Repair with a concurrent lookup: lookup still sees GHR 5
        drive(1, 32'h500, 1, 32'h400, 8'h05, 0, 1);
        #1; chk("rep_take", take[0], 1);
        cyc();
        idle();
        #1; chk("rep_ghr", pghr[0], 8'h0A);

        // Saturation at 0
        set_ghr(8'h00);
        repeat (4) upd(32'h100, 8'h00, 0);
        pred_pc = 32'h100;
        #1; chk("sat_lo", take[0], 0);
        upd(32'h100, 8'h00, 1);
        upd(32'h100, 8'h00, 1);
        pred_pc = 32'h100;
        #1; chk("sat_lo_up", take[0], 1);
        cyc();

        // Flush wins over a concurrent update; updates during INIT are dropped
        drive(0, 32'h100, 1, 32'h100, 8'h00, 1, 0);
        flush_tbl = 1'b1;
        cyc();
        flush_tbl = 1'b0;
        chk("flush_busy", busy[0], 1);
        wait_ready("flush_len");
        idle();
        pred_pc = 32'h100;
        #1; chk("flush_take", take[0], 0);
        upd(32'h100, 8'h00, 1);
        pred_pc = 32'h100;
        #1; chk("flush_01", take[0], 1);
        cyc();

        // Async reset mid-walk restarts it from entry 0
        flush_tbl = 1'b1;
        cyc();
        idle();
        repeat (300) cyc();
        #2;
        rst = 1'b1;
        m_run = 0; m_cnt = 0; m_ghr[0] = 0; m_ghr[1] = 0;
        #1;
        chk("mid_rst_rdy", rdy[0], 0);
        cyc();
        rst = 1'b0;
        wait_ready("rst_len");
        pred_pc = 32'h100;
        #1; chk("rst_take_01", take[0], 0);

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(0, 1), $urandom_range(0, 255) * 4,
                  ($urandom_range(0, 2) == 0), $urandom_range(0, 255) * 4,
                  8'($urandom_range(0, 255)), $urandom_range(0, 1),
                  ($urandom_range(0, 3) == 0));
            flush_tbl = ($urandom_range(0, 1499) == 0);
            cyc();
        end
        idle();
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
